// File: rtl/avmm_master_pkg.sv
// Shared types and constants for the single-outstanding Avalon-MM command master.
// Holds the FSM state encoding, the Avalon response codes and the counter width.
package avmm_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Wide enough for the largest legal watchdog limit.
    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/avmm_watchdog.sv
// Loadable saturating up-counter with clear and enable.
// Expiry fires in the enabled cycle whose increment would reach the limit.
module avmm_watchdog
    import avmm_master_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Compare with one extra bit so a saturated count cannot wrap past the limit.
    assign expire = en && (({1'b0, count_q} + {{W{1'b0}}, 1'b1}) >= {1'b0, limit});

endmodule

// File: rtl/avmm_cmd_master.sv
// Converts one command-stream beat into one Avalon-MM read or write and returns
// a single response beat; a watchdog forces completion if the slave stays silent.
module avmm_cmd_master
    import avmm_master_pkg::*;
#(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned FIXED_LATENCY = 0,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic [1:0]        rsp_response,
    output logic              rsp_timeout,
    output logic              err_late_rsp,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_writeresponsevalid,
    input  logic [1:0]        avm_response
);

    localparam bit USE_FIXED_LAT = (FIXED_LATENCY != 0);

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              is_write_q, is_write_d;
    logic              avm_read_q, avm_read_d;
    logic              avm_write_q, avm_write_d;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic [DATA_W-1:0] avm_writedata_q, avm_writedata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_readdata_q, rsp_readdata_d;
    logic [1:0]        rsp_response_q, rsp_response_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              err_late_q, err_late_d;

    logic cmd_fire;
    logic rsp_fire;
    logic req_accept;
    logic slave_pulse;
    logic any_pulse;
    logic late_pulse;
    logic lat_expire;
    logic tmo_expire;
    logic completion;

    assign cmd_fire    = cmd_valid && cmd_ready_q;
    assign rsp_fire    = rsp_valid_q && rsp_ready;
    assign req_accept  = (state_q == REQ) && (avm_read_q || avm_write_q) && !avm_waitrequest;
    assign slave_pulse = is_write_q ? avm_writeresponsevalid : avm_readdatavalid;
    assign any_pulse   = avm_readdatavalid || avm_writeresponsevalid;

    // Only a pulse that can be matched to an outstanding request is legal.
    assign late_pulse  = !USE_FIXED_LAT && any_pulse && (state_q != WAIT);
    assign completion  = USE_FIXED_LAT ? lat_expire : ((state_q == WAIT) && slave_pulse);

    avmm_watchdog #(.W(CNT_W)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr      (cmd_fire),
        .load     (1'b0),
        .load_val ('0),
        .en       ((state_q == REQ) || (state_q == WAIT)),
        .limit    (CNT_W'(TIMEOUT)),
        .expire   (tmo_expire)
    );

    avmm_watchdog #(.W(CNT_W)) u_latency (
        .clk      (clk),
        .reset    (reset),
        .clr      (cmd_fire),
        .load     (req_accept),
        .load_val ('0),
        .en       (state_q == WAIT),
        .limit    (CNT_W'(FIXED_LATENCY)),
        .expire   (lat_expire)
    );

    always_comb begin
        state_d         = state_q;
        is_write_d      = is_write_q;
        avm_read_d      = avm_read_q;
        avm_write_d     = avm_write_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_readdata_d  = rsp_readdata_q;
        rsp_response_d  = rsp_response_q;
        rsp_timeout_d   = rsp_timeout_q;
        err_late_d      = err_late_q || late_pulse;

        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d         = REQ;
                    is_write_d      = cmd_write;
                    avm_address_d   = cmd_address;
                    avm_writedata_d = cmd_writedata;
                    avm_read_d      = !cmd_write;
                    avm_write_d     = cmd_write;
                end
            end
            REQ: begin
                // Timeout wins over a same-cycle acceptance: the request is abandoned.
                if (tmo_expire) begin
                    state_d        = RSP;
                    avm_read_d     = 1'b0;
                    avm_write_d    = 1'b0;
                    rsp_valid_d    = 1'b1;
                    rsp_readdata_d = '0;
                    rsp_response_d = RESP_DECERR;
                    rsp_timeout_d  = 1'b1;
                end else if (req_accept) begin
                    state_d     = WAIT;
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                end
            end
            WAIT: begin
                // A real completion beats a same-cycle timeout.
                if (completion) begin
                    state_d        = RSP;
                    rsp_valid_d    = 1'b1;
                    rsp_readdata_d = is_write_q ? '0 : avm_readdata;
                    rsp_response_d = avm_response;
                    rsp_timeout_d  = 1'b0;
                end else if (tmo_expire) begin
                    state_d        = RSP;
                    rsp_valid_d    = 1'b1;
                    rsp_readdata_d = '0;
                    rsp_response_d = RESP_DECERR;
                    rsp_timeout_d  = 1'b1;
                end
            end
            RSP: begin
                if (rsp_fire) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered, so it stays low for the first cycle after reset release.
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cmd_ready_q     <= 1'b0;
            is_write_q      <= 1'b0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_readdata_q  <= '0;
            rsp_response_q  <= RESP_OKAY;
            rsp_timeout_q   <= 1'b0;
            err_late_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmd_ready_q     <= cmd_ready_d;
            is_write_q      <= is_write_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_readdata_q  <= rsp_readdata_d;
            rsp_response_q  <= rsp_response_d;
            rsp_timeout_q   <= rsp_timeout_d;
            err_late_q      <= err_late_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_readdata  = rsp_readdata_q;
    assign rsp_response  = rsp_response_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign err_late_rsp  = err_late_q;
    assign avm_address   = avm_address_q;
    assign avm_read      = avm_read_q;
    assign avm_write     = avm_write_q;
    assign avm_writedata = avm_writedata_q;

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Bench for avmm_cmd_master: instance A uses fixed latency 1, instance B uses
// completion pulses; a transaction-level model predicts every response.
module tb_avmm_cmd_master;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int FL_A   = 1;
    localparam int TMO_A  = 12;
    localparam int TMO_B  = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        cmd_valid, cmd_write, rsp_ready;
    logic [1:0]        avm_waitrequest, avm_readdatavalid, avm_writeresponsevalid;
    logic [ADDR_W-1:0] cmd_address [2];
    logic [DATA_W-1:0] cmd_writedata [2];
    logic [DATA_W-1:0] avm_readdata [2];
    logic [1:0]        avm_response [2];

    wire [1:0]         cmd_ready, rsp_valid, rsp_timeout, err_late_rsp, avm_read, avm_write;
    wire [DATA_W-1:0]  rsp_readdata [2];
    wire [1:0]         rsp_response [2];
    wire [ADDR_W-1:0]  avm_address [2];
    wire [DATA_W-1:0]  avm_writedata [2];

    avmm_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_LATENCY(FL_A), .TIMEOUT(TMO_A)) u_dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
        .cmd_address(cmd_address[0]), .cmd_writedata(cmd_writedata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_readdata(rsp_readdata[0]),
        .rsp_response(rsp_response[0]), .rsp_timeout(rsp_timeout[0]), .err_late_rsp(err_late_rsp[0]),
        .avm_address(avm_address[0]), .avm_read(avm_read[0]), .avm_write(avm_write[0]),
        .avm_writedata(avm_writedata[0]), .avm_waitrequest(avm_waitrequest[0]),
        .avm_readdata(avm_readdata[0]), .avm_readdatavalid(avm_readdatavalid[0]),
        .avm_writeresponsevalid(avm_writeresponsevalid[0]), .avm_response(avm_response[0])
    );

    avmm_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_LATENCY(0), .TIMEOUT(TMO_B)) u_dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
        .cmd_address(cmd_address[1]), .cmd_writedata(cmd_writedata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_readdata(rsp_readdata[1]),
        .rsp_response(rsp_response[1]), .rsp_timeout(rsp_timeout[1]), .err_late_rsp(err_late_rsp[1]),
        .avm_address(avm_address[1]), .avm_read(avm_read[1]), .avm_write(avm_write[1]),
        .avm_writedata(avm_writedata[1]), .avm_waitrequest(avm_waitrequest[1]),
        .avm_readdata(avm_readdata[1]), .avm_readdatavalid(avm_readdatavalid[1]),
        .avm_writeresponsevalid(avm_writeresponsevalid[1]), .avm_response(avm_response[1])
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] err_exp = 2'b00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic slave_quiet(input int i);
        avm_waitrequest[i]        = 1'b0;
        avm_readdatavalid[i]      = 1'b0;
        avm_writeresponsevalid[i] = 1'b0;
        avm_response[i]           = 2'b00;
        avm_readdata[i]           = '0;
    endtask

    // One command end to end. Cycle c counts REQ/WAIT cycles from 1 after the
    // command handshake; the slave accepts in cycle n_wait+1 and completes in
    // cycle acc+1 (fixed latency) or in cycle c_p (pulse, 0 = never).
    task automatic run_txn(input int i, input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int n_wait, input int c_p,
                           input logic [1:0] resp, input logic [DATA_W-1:0] rdata, input int hold);
        int tmo, acc, done_c, fin_c, strobe_last, c, guard;
        bit completes, exp_strobe;
        logic [1:0] exp_resp;
        logic [DATA_W-1:0] exp_data;

        tmo         = (i == 0) ? TMO_A : TMO_B;
        acc         = n_wait + 1;
        done_c      = (i == 0) ? acc + FL_A : c_p;
        completes   = (acc < tmo) && (done_c != 0) && (done_c <= tmo);
        fin_c       = completes ? done_c : tmo;
        strobe_last = (acc < tmo) ? acc : tmo;
        exp_resp    = completes ? resp : 2'b11;
        exp_data    = (completes && !wr) ? rdata : '0;
        if ((i == 1) && (c_p > tmo)) err_exp[1] = 1'b1;

        cmd_valid[i] = 1'b1; cmd_write[i] = wr; cmd_address[i] = addr; cmd_writedata[i] = wdata;
        guard = 0;
        while ((cmd_ready[i] !== 1'b1) && (guard < 20)) begin
            step();
            guard++;
        end
        check("cmd_accept", 64'(guard < 20), 64'd1);
        step();
        cmd_valid[i] = 1'b0; cmd_write[i] = 1'($urandom);
        cmd_address[i] = ADDR_W'($urandom); cmd_writedata[i] = $urandom;

        for (c = 1; c < 300; c++) begin
            avm_waitrequest[i] = (c <= n_wait);
            avm_response[i]    = (c == done_c) ? resp : 2'($urandom);
            avm_readdata[i]    = (c == done_c) ? rdata : $urandom;
            if (i == 0) begin
                avm_readdatavalid[0]      = 1'($urandom);
                avm_writeresponsevalid[0] = 1'($urandom);
            end else begin
                avm_readdatavalid[1]      = (c == c_p) && !wr;
                avm_writeresponsevalid[1] = (c == c_p) && wr;
            end
            exp_strobe = (c <= strobe_last);
            check("avm_read", avm_read[i], exp_strobe && !wr);
            check("avm_write", avm_write[i], exp_strobe && wr);
            if (exp_strobe) begin
                check("avm_address", avm_address[i], addr);
                if (wr) check("avm_writedata", avm_writedata[i], wdata);
            end
            check("cmd_ready_busy", cmd_ready[i], 1'b0);
            if (rsp_valid[i] === 1'b1) break;
            step();
        end
        check("rsp_latency", c, fin_c + 1);

        rsp_ready[i] = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) rsp_ready[i] = 1'b1;
            check("rsp_valid", rsp_valid[i], 1'b1);
            check("rsp_readdata", rsp_readdata[i], exp_data);
            check("rsp_response", rsp_response[i], exp_resp);
            check("rsp_timeout", rsp_timeout[i], !completes);
            check("cmd_ready_hold", cmd_ready[i], 1'b0);
            step();
            slave_quiet(i);
        end
        rsp_ready[i] = 1'b0;
        check("rsp_valid_drop", rsp_valid[i], 1'b0);
        check("cmd_ready_return", cmd_ready[i], 1'b1);
        check("err_late_rsp", err_late_rsp[i], err_exp[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int guard;
        int i, n_wait, c_p, tmo;
        cmd_valid = '0; cmd_write = '0; rsp_ready = '0;
        for (int k = 0; k < 2; k++) begin
            cmd_address[k] = '0; cmd_writedata[k] = '0;
            slave_quiet(k);
        end

        // Reset state.
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            check("rst_cmd_ready", cmd_ready[k], 1'b0);
            check("rst_rsp_valid", rsp_valid[k], 1'b0);
            check("rst_avm_read", avm_read[k], 1'b0);
            check("rst_avm_write", avm_write[k], 1'b0);
            check("rst_err_late", err_late_rsp[k], 1'b0);
            check("rst_rsp_response", rsp_response[k], 2'b00);
            check("rst_rsp_readdata", rsp_readdata[k], 0);
            check("rst_avm_address", avm_address[k], 0);
        end
        reset = 1'b1;
        #1 check("rel_cmd_ready_first", cmd_ready[0], 1'b0);
        step();
        check("rel_cmd_ready_a", cmd_ready[0], 1'b1);
        check("rel_cmd_ready_b", cmd_ready[1], 1'b1);

        // Error slave read, fixed latency 1.
        run_txn(0, 1'b0, 16'h0010, 32'h0, 0, 0, 2'b10, 32'h0, 0);
        // Write held off by waitrequest for 5 cycles.
        run_txn(0, 1'b1, 16'h1234, 32'hDEADBEEF, 5, 0, 2'b00, $urandom, 1);
        // Silent slave: watchdog, then a stray pulse in IDLE.
        run_txn(1, 1'b0, 16'h0020, 32'h0, 0, 0, 2'b10, 32'h0, 1);
        avm_readdatavalid[1] = 1'b1;
        step();
        avm_readdatavalid[1] = 1'b0;
        step();
        err_exp[1] = 1'b1;
        check("err_late_set", err_late_rsp[1], 1'b1);
        // Completion on the exact timeout cycle.
        run_txn(1, 1'b0, 16'h0030, 32'h0, 0, TMO_B, 2'b10, 32'hCAFEF00D, 0);
        // Response back-pressured for 10 cycles.
        run_txn(0, 1'b0, 16'h0040, 32'h0, 2, 0, 2'b01, 32'h12345678, 10);

        for (int n = 0; n < 40; n++) begin
            i      = n % 2;
            tmo    = (i == 0) ? TMO_A : TMO_B;
            n_wait = $urandom_range(0, tmo);
            if ((n_wait + 1 >= tmo) || ($urandom_range(0, 4) == 0)) c_p = 0;
            else c_p = $urandom_range(n_wait + 2, tmo + 1);
            run_txn(i, 1'($urandom), ADDR_W'($urandom), $urandom, n_wait, c_p,
                    2'($urandom), $urandom, $urandom_range(0, 3));
        end

        // Reset while a read is stalled in REQ.
        cmd_valid[1] = 1'b1; cmd_write[1] = 1'b0; cmd_address[1] = 16'h0BAD;
        avm_waitrequest[1] = 1'b1;
        guard = 0;
        while ((cmd_ready[1] !== 1'b1) && (guard < 20)) begin
            step();
            guard++;
        end
        step();
        cmd_valid[1] = 1'b0;
        check("mid_pre_read", avm_read[1], 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid_avm_read", avm_read[1], 1'b0);
        check("mid_rsp_valid", rsp_valid[1], 1'b0);
        check("mid_cmd_ready", cmd_ready[1], 1'b0);
        check("mid_err_late", err_late_rsp[1], 1'b0);
        check("mid_avm_address", avm_address[1], 0);
        step();
        reset = 1'b1;
        err_exp = 2'b00;
        avm_waitrequest[1] = 1'b0;
        #1 check("mid_rel_first", cmd_ready[1], 1'b0);
        step();
        check("mid_rel_second", cmd_ready[1], 1'b1);
        check("mid_discarded", rsp_valid[1], 1'b0);
        run_txn(1, 1'b1, 16'h0ABC, 32'h0F0F0F0F, 1, 4, 2'b00, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
